// File: rtl/pixel_out_stream_pkg.sv
// Shared definitions for the 8x8 reconstruction / output path.
// Holds the pixel-block geometry and the read-side FSM state encoding so that
// every block working on 8x8 tiles agrees on them.
package pixel_out_stream_pkg;

   localparam int unsigned BLK_PIX = 64;  // pixels per 8x8 block
   localparam int unsigned BLK_AW  = 6;   // address width for one block

   typedef enum logic {
      R_IDLE = 1'b0,
      R_SEND = 1'b1
   } rd_state_e;

endpackage

// File: rtl/pixel_sat_round.sv
// Fixed-point to unsigned 8-bit pixel conversion (purely combinational).
// Rounds half-up by adding 2^(FRAC_BITS-1), arithmetic-shifts right by FRAC_BITS,
// then clamps into 0..255.
// Ports:
//   val_i  24-bit signed fixed-point value, FRAC_BITS fractional bits
//   pix_o  8-bit unsigned saturated pixel
// FRAC_BITS must be at least 1.
module pixel_sat_round #(
   parameter int unsigned FRAC_BITS = 16
) (
   input  logic [23:0] val_i,
   output logic [7:0]  pix_o
);

   localparam logic signed [24:0] HALF = 25'sd1 <<< (FRAC_BITS - 1);

   // One guard bit so the rounding add cannot wrap near full scale.
   logic signed [24:0] sum;
   logic signed [24:0] quo;

   always_comb begin
      sum = $signed({val_i[23], val_i}) + HALF;
      quo = sum >>> FRAC_BITS;
      if (quo[24]) begin
         pix_o = 8'h00;
      end else if (quo > 25'sd255) begin
         pix_o = 8'hFF;
      end else begin
         pix_o = quo[7:0];
      end
   end

endmodule

// File: rtl/pixel_out_stream.sv
// Ping-pong output buffer between the reconstruction stage and a valid/ready
// pixel stream. Pixels are converted to u8 on write, a block is committed with
// block_c_done and then streamed in address order 0..63.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   pixel_addr/val/we        pixel write into the current write bank
//   block_c_done             commit the write bank (one-cycle pulse)
//   m_valid/m_ready/m_data   output pixel stream, m_last marks pixel 63
//   overrun                  sticky: write/commit dropped because write bank full
//   blocks_out               number of blocks fully streamed (wraps)
module pixel_out_stream
   import pixel_out_stream_pkg::*;
#(
   parameter int unsigned FRAC_BITS = 16,
   parameter int unsigned CNT_W     = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [BLK_AW-1:0] pixel_addr,
   input  logic [23:0]       pixel_val,
   input  logic              pixel_we,
   input  logic              block_c_done,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [7:0]        m_data,
   output logic              m_last,
   output logic              overrun,
   output logic [CNT_W-1:0]  blocks_out
);

   localparam logic [BLK_AW-1:0] LAST_PIX = BLK_AW'(BLK_PIX - 1);

   logic [7:0] pix_conv;
   logic [7:0] bank_mem [2][BLK_PIX];

   logic [BLK_PIX-1:0] mask_q [2];
   logic [BLK_PIX-1:0] mask_d [2];
   logic [1:0]         full_q, full_d;
   logic               wr_bank_q, wr_bank_d;
   logic               rd_bank_q, rd_bank_d;
   logic [BLK_AW-1:0]  rd_cnt_q, rd_cnt_d;
   rd_state_e          state_q, state_d;
   logic               m_valid_q, m_valid_d;
   logic [7:0]         m_data_q, m_data_d;
   logic               m_last_q, m_last_d;
   logic               overrun_q, overrun_d;
   logic [CNT_W-1:0]   blocks_q, blocks_d;

   logic               wr_blocked, write_ok, commit_ok;
   logic               handshake, release_blk;
   logic [BLK_PIX-1:0] rd_mask;
   logic [7:0]         rd_pix;

   pixel_sat_round #(
      .FRAC_BITS(FRAC_BITS)
   ) u_sat (
      .val_i(pixel_val),
      .pix_o(pix_conv)
   );

   // Bank data carries no reset; the mask decides what is valid.
   always_ff @(posedge clk) begin
      if (write_ok) begin
         bank_mem[wr_bank_q][pixel_addr] <= pix_conv;
      end
   end

   always_comb begin
      wr_blocked  = full_q[wr_bank_q];
      write_ok    = pixel_we & ~wr_blocked;
      commit_ok   = block_c_done & ~wr_blocked;
      handshake   = m_valid_q & m_ready;
      release_blk = handshake & (rd_cnt_q == LAST_PIX);

      full_d    = full_q;
      mask_d    = mask_q;
      wr_bank_d = wr_bank_q;
      rd_bank_d = rd_bank_q;
      rd_cnt_d  = rd_cnt_q;
      state_d   = state_q;
      blocks_d  = blocks_q;
      overrun_d = overrun_q | (wr_blocked & (pixel_we | block_c_done));

      // Write side. A commit in the same cycle as a write still sees the
      // write, since both target wr_bank_q on this edge.
      if (write_ok) begin
         mask_d[wr_bank_q][pixel_addr] = 1'b1;
      end
      if (commit_ok) begin
         full_d[wr_bank_q] = 1'b1;
         wr_bank_d         = ~wr_bank_q;
      end

      // Read side. The released bank is full, so it can never be the bank a
      // commit or write touches on the same edge.
      case (state_q)
         R_IDLE: begin
            if (full_q[rd_bank_q]) begin
               state_d  = R_SEND;
               rd_cnt_d = '0;
            end
         end
         R_SEND: begin
            if (release_blk) begin
               full_d[rd_bank_q] = 1'b0;
               mask_d[rd_bank_q] = '0;
               rd_bank_d         = ~rd_bank_q;
               blocks_d          = blocks_q + CNT_W'(1);
               rd_cnt_d          = '0;
               state_d           = full_q[~rd_bank_q] ? R_SEND : R_IDLE;
            end else if (handshake) begin
               rd_cnt_d = rd_cnt_q + BLK_AW'(1);
            end
         end
         default: state_d = R_IDLE;
      endcase

      // Outputs are registered from the next read position; the bank being
      // read is full, so its data and mask are stable across this edge.
      rd_mask   = mask_q[rd_bank_d];
      rd_pix    = bank_mem[rd_bank_d][rd_cnt_d];
      m_valid_d = (state_d == R_SEND);
      m_data_d  = (m_valid_d && rd_mask[rd_cnt_d]) ? rd_pix : 8'h00;
      m_last_d  = m_valid_d && (rd_cnt_d == LAST_PIX);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q[0] <= '0;
         mask_q[1] <= '0;
         full_q    <= '0;
         wr_bank_q <= 1'b0;
         rd_bank_q <= 1'b0;
         rd_cnt_q  <= '0;
         state_q   <= R_IDLE;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_last_q  <= 1'b0;
         overrun_q <= 1'b0;
         blocks_q  <= '0;
      end else begin
         mask_q    <= mask_d;
         full_q    <= full_d;
         wr_bank_q <= wr_bank_d;
         rd_bank_q <= rd_bank_d;
         rd_cnt_q  <= rd_cnt_d;
         state_q   <= state_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_last_q  <= m_last_d;
         overrun_q <= overrun_d;
         blocks_q  <= blocks_d;
      end
   end

   assign m_valid    = m_valid_q;
   assign m_data     = m_data_q;
   assign m_last     = m_last_q;
   assign overrun    = overrun_q;
   assign blocks_out = blocks_q;

endmodule

// File: doc/pixel_out_stream.md
PIXEL_OUT_STREAM -- requirements
Module: pixel_out_stream

Interface
REQ-001 SHALL have parameter FRAC_BITS, default 16, giving the number of fractional bits in pixel_val (signed fixed-point).
REQ-002 SHALL have parameter CNT_W, default 16, giving the width of blocks_out.
REQ-003 clk  input  1  sole clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 pixel_addr  input  6  pixel index in 8x8 block (row*8+col), from the reconstruction stage.
REQ-006 pixel_val  input  24  signed reconstructed coefficient, Q(23-FRAC_BITS).FRAC_BITS.
REQ-007 pixel_we  input  1  write strobe for pixel_addr/pixel_val.
REQ-008 block_c_done  input  1  one-cycle pulse: current block complete, commit bank.
REQ-009 m_valid  output  1  output pixel valid.
REQ-010 m_ready  input  1  downstream accepts pixel when m_valid&&m_ready.
REQ-011 m_data  output  8  unsigned 8-bit pixel.
REQ-012 m_last  output  1  high with pixel 63 of a block.
REQ-013 overrun  output  1  sticky error: write or commit arrived while the write bank was full.
REQ-014 blocks_out  output  CNT_W  count of blocks fully streamed; wraps modulo 2^CNT_W.

Function
REQ-015 SHALL hold two 64x8 banks (ping-pong), a per-bank 64-bit written mask, a full flag per bank, wr_bank and rd_bank pointers.
REQ-016 Conversion, applied at write: add 2^(FRAC_BITS-1), arithmetic shift right FRAC_BITS, clamp to 0..255 (negative -> 0, >255 -> 255); stored value is 8-bit.
REQ-017 pixel_we with bank[wr_bank] not full SHALL store the converted value at pixel_addr and set mask bit; repeated address overwrites (last write wins).
REQ-018 block_c_done with bank[wr_bank] not full SHALL set full[wr_bank] and toggle wr_bank on the same edge.
REQ-019 pixel_we and block_c_done in the same cycle: the write SHALL land in the bank being committed.
REQ-020 pixel_we or block_c_done while bank[wr_bank] full SHALL be dropped, set overrun, and leave bank contents/flags unchanged.
REQ-021 Read FSM states: R_IDLE, R_SEND. R_IDLE: m_valid=0; if full[rd_bank] -> R_SEND with rd_cnt=0.
REQ-022 R_SEND: m_valid=1, m_data = mask[rd_cnt] ? bank[rd_bank][rd_cnt] : 0, m_last = (rd_cnt==63); m_data/m_last SHALL stay stable while m_valid&&!m_ready.
REQ-023 On handshake with rd_cnt<63: rd_cnt+1, stay R_SEND (one pixel per cycle sustained).
REQ-024 On handshake with rd_cnt==63: clear full[rd_bank] and mask[rd_bank], toggle rd_bank, blocks_out+1; next state R_SEND (rd_cnt=0) if the other bank is full, else R_IDLE.
REQ-025 Latency: commit to first m_valid = 1 cycle when the read side is idle.
REQ-026 Commit into one bank and release of the other in the same cycle SHALL both take effect; no lost or duplicated block.
REQ-027 Blocks SHALL be emitted in commit order; pixels in address order 0..63.

Reset
REQ-028 While rst high: m_valid=0, m_data=0, m_last=0, overrun=0, blocks_out=0, full flags=0, masks=0, wr_bank=rd_bank=0, rd_cnt=0, state R_IDLE; bank data need not be reset.
REQ-029 Reset mid-block SHALL discard all buffered and partially streamed data; first block after release starts at pixel 0 in bank 0.

Structure
REQ-030 Read-FSM state encodings and the pixel-block size (64) SHALL live in the shared package used by the reconstruction blocks.
REQ-031 Fixed-point-to-u8 conversion SHALL be a sub-module pixel_sat_round (combinational, parameter FRAC_BITS); everything else in pixel_out_stream.

Verification
REQ-032 Write addr k with val k<<16 for k=0..63, commit, m_ready=1 -> m_data 0..63 on consecutive cycles, m_last on 63, blocks_out=1.
REQ-033 Vals 0x007F80 (0.498), 0x008000 (0.5), 0xFF0000 (-1.0), 0x7FFFFF -> m_data 0, 1, 0, 255.
REQ-034 Write only addr 5 (val 10<<16), commit -> 64 pixels, all 0 except pixel 5 = 10.
REQ-035 m_ready toggled 1/0 each cycle across a block -> every pixel once, stable during stalls, no reorder.
REQ-036 m_ready=0, commit two blocks, then a third write+commit -> overrun=1, third dropped; release m_ready -> exactly blocks 1 and 2 emitted, blocks_out=2.
REQ-037 Assert rst during pixel 30 of streaming -> m_valid=0 next, all flags cleared; new block afterwards streams correctly from pixel 0.
